// File: rtl/alu_mul_sequencer_pkg.sv
// Shared ALU opcode/flag definitions and multiplier sequencer state encoding.
// The opcodes and flag indices must match the CPU's ALU.
package alu_mul_sequencer_pkg;

  localparam logic [3:0] ALU_TRA = 4'h0;
  localparam logic [3:0] ALU_ADD = 4'h1;
  localparam logic [3:0] ALU_ROR = 4'hB;

  // Status byte layout: ---SVNZC
  localparam int CF = 0;
  localparam int ZF = 1;
  localparam int NF = 2;
  localparam int VF = 3;
  localparam int SF = 4;

  typedef enum logic [2:0] {
    MUL_IDLE = 3'd0,
    MUL_ACC  = 3'd1,
    MUL_SHH  = 3'd2,
    MUL_SHL  = 3'd3,
    MUL_FIN  = 3'd4
  } mul_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// 8x8 unsigned shift-and-add multiplier that borrows the shared 8-bit ALU
// (ADD/TRA to accumulate, ROR through carry to shift {H,L}) for 8 iterations.
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [7:0]  OP_A,
  input  logic [7:0]  OP_B,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] RESULT,
  output logic [7:0]  ST_RESULT,
  output logic [3:0]  ALU_OPERATION,
  output logic [7:0]  ALU_A,
  output logic [7:0]  ALU_B,
  output logic [7:0]  ALU_ST_IN,
  input  logic [7:0]  ALU_R,
  input  logic [7:0]  ALU_ST_OUT
);

  mul_state_t state;
  logic [7:0] m;
  logic [7:0] h;
  logic [7:0] l;
  logic       c;
  logic [2:0] cnt;
  logic       unused_st_out;

  // Only the carry flag of the ALU status is consumed.
  assign unused_st_out = ^ALU_ST_OUT;

  function automatic logic [7:0] product_status(input logic [15:0] p);
    logic [7:0] st;
    st     = 8'h00;
    st[ZF] = (p == 16'h0000);
    st[CF] = (p[15:8] != 8'h00);
    return st;
  endfunction

  always_comb begin
    ALU_OPERATION = ALU_TRA;
    ALU_A         = 8'h00;
    ALU_B         = 8'h00;
    ALU_ST_IN     = 8'h00;
    case (state)
      MUL_ACC: begin
        ALU_OPERATION = l[0] ? ALU_ADD : ALU_TRA;
        ALU_A         = h;
        ALU_B         = m;
      end
      MUL_SHH: begin
        ALU_OPERATION = ALU_ROR;
        ALU_A         = h;
        ALU_ST_IN[CF] = c;
      end
      MUL_SHL: begin
        ALU_OPERATION = ALU_ROR;
        ALU_A         = l;
        ALU_ST_IN[CF] = c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= MUL_IDLE;
      m         <= 8'h00;
      h         <= 8'h00;
      l         <= 8'h00;
      c         <= 1'b0;
      cnt       <= 3'd0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      RESULT    <= 16'h0000;
      ST_RESULT <= 8'h00;
    end else begin
      DONE <= 1'b0;
      case (state)
        MUL_IDLE: begin
          if (START) begin
            m     <= OP_A;
            l     <= OP_B;
            h     <= 8'h00;
            c     <= 1'b0;
            cnt   <= 3'd0;
            BUSY  <= 1'b1;
            state <= MUL_ACC;
          end
        end
        MUL_ACC: begin
          h     <= ALU_R;
          c     <= ALU_ST_OUT[CF];
          state <= MUL_SHH;
        end
        MUL_SHH: begin
          h     <= ALU_R;
          c     <= ALU_ST_OUT[CF];
          state <= MUL_SHL;
        end
        MUL_SHL: begin
          l   <= ALU_R;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            // Capture the product here so it is already valid while DONE is high.
            RESULT    <= {h, ALU_R};
            ST_RESULT <= product_status({h, ALU_R});
            DONE      <= 1'b1;
            state     <= MUL_FIN;
          end else begin
            state <= MUL_ACC;
          end
        end
        MUL_FIN: begin
          BUSY  <= 1'b0;
          state <= MUL_IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          state <= MUL_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Closes the loop with a behavioural ALU and checks products, status, timing
// and handshake behaviour against plain integer multiplication.
`timescale 1ns/1ps
module tb_alu_mul_sequencer;
  import alu_mul_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [7:0]  st_result;
  logic [3:0]  alu_operation;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_st_in;
  logic [7:0]  alu_r;
  logic [7:0]  alu_st_out;

  int checks   = 0;
  int failures = 0;
  logic [15:0] prev_p;
  logic [7:0]  prev_st;

  always #5 clk = ~clk;

  alu_mul_sequencer dut (
    .CLK(clk), .RESET(rst), .START(start), .OP_A(op_a), .OP_B(op_b),
    .BUSY(busy), .DONE(done), .RESULT(result), .ST_RESULT(st_result),
    .ALU_OPERATION(alu_operation), .ALU_A(alu_a), .ALU_B(alu_b),
    .ALU_ST_IN(alu_st_in), .ALU_R(alu_r), .ALU_ST_OUT(alu_st_out)
  );

  // Behavioural ALU: ADD sets carry-out, TRA passes A with carry clear,
  // ROR rotates through the incoming carry.
  always_comb begin
    alu_r      = alu_a;
    alu_st_out = 8'h00;
    case (alu_operation)
      ALU_ADD: {alu_st_out[CF], alu_r} = {1'b0, alu_a} + {1'b0, alu_b};
      ALU_ROR: begin
        alu_r          = {alu_st_in[CF], alu_a[7:1]};
        alu_st_out[CF] = alu_a[0];
      end
      default: alu_r = alu_a;
    endcase
    alu_st_out[ZF] = (alu_r == 8'h00);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_status(input int p);
    logic [7:0] st;
    st = 8'h00;
    if (p == 0)   st[1] = 1'b1;
    if (p > 255)  st[0] = 1'b1;
    return st;
  endfunction

  task automatic run_mul(input logic [7:0] a, input logic [7:0] b,
                         input bit poke_busy, input bit poke_fin);
    int          p;
    int          n;
    int          busy_n;
    int          acc_i;
    bit          stable;
    bit          seen;
    logic [7:0]  add_mask;
    p        = int'(a) * int'(b);
    n        = 0;
    busy_n   = 0;
    acc_i    = 0;
    stable   = 1'b1;
    seen     = 1'b0;
    add_mask = 8'h00;
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (n < 40 && !seen) begin
      if (busy) busy_n++;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (result !== prev_p || st_result !== prev_st) stable = 1'b0;
        if (busy && (alu_operation == ALU_ADD || alu_operation == ALU_TRA)) begin
          if (acc_i < 8) add_mask[acc_i] = (alu_operation == ALU_ADD);
          acc_i++;
        end
        if (poke_busy && n == 5) begin
          op_a  = ~a;
          op_b  = 8'h5A;
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1;
        n++;
      end
    end
    start = 1'b0;
    check("done_latency", n, 24);
    check("busy_cycles", busy_n, 25);
    check("result", result, p[15:0]);
    check("st_result", st_result, ref_status(p));
    check("prev_stable", stable, 1);
    check("acc_steps", acc_i, 8);
    check("acc_op_pattern", add_mask, b);
    if (poke_fin) begin
      op_a  = 8'hFF;
      op_b  = 8'hFF;
      start = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("done_pulse", done, 0);
    check("idle_after_fin", busy, 0);
    check("result_held", result, p[15:0]);
    prev_p  = p[15:0];
    prev_st = ref_status(p);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op_a  = 8'h00;
    op_b  = 8'h00;
    prev_p  = 16'h0000;
    prev_st = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_st", st_result, 0);
    check("rst_alu_op", alu_operation, ALU_TRA);
    @(negedge clk);
    rst = 1'b0;

    run_mul(8'd13, 8'd11, 1'b0, 1'b0);
    run_mul(8'd255, 8'd255, 1'b0, 1'b1);
    run_mul(8'd0, 8'd200, 1'b0, 1'b0);
    run_mul(8'd16, 8'd16, 1'b1, 1'b0);

    // Mid-run reset, with START held during reset.
    @(negedge clk);
    op_a  = 8'd200;
    op_b  = 8'd100;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    check("midrst_st", st_result, 0);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    check("start_with_rst_ignored", busy, 0);
    prev_p  = 16'h0000;
    prev_st = 8'h00;
    run_mul(8'd3, 8'd5, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      run_mul(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
